// File: rtl/uart_pkg.sv
// Shared UART types and helpers.
// Contents:
//   rx_state_e      - receive FSM state encoding
//   DATA_BITS_*     - data_bit_num encodings (00=5 .. 11=8 data bits)
//   PARITY_EVEN/ODD - parity_type encodings
//   data_bit_count  - maps a data_bit_num code to its number of data bits
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic [1:0] DATA_BITS_5 = 2'b00;
    localparam logic [1:0] DATA_BITS_6 = 2'b01;
    localparam logic [1:0] DATA_BITS_7 = 2'b10;
    localparam logic [1:0] DATA_BITS_8 = 2'b11;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic logic [3:0] data_bit_count(input logic [1:0] data_bit_num);
        return 4'd5 + {2'b00, data_bit_num};
    endfunction

endpackage

// File: rtl/uart_parity.sv
// Parity generator shared by the UART transmit and receive paths.
// Ports:
//   data        - byte to protect (unused MSBs must be zero)
//   parity_type - PARITY_EVEN or PARITY_ODD
//   parity_bit  - bit that makes the total ones count even/odd
module uart_parity
    import uart_pkg::*;
(
    input  logic [7:0] data,
    input  logic       parity_type,
    output logic       parity_bit
);

    assign parity_bit = (^data) ^ (parity_type == PARITY_ODD);

endmodule

// File: rtl/uart_rx_sampler.sv
// Receive-side line conditioning: synchronizes rx into the clk domain and
// counts baud ticks modulo OVERSAMPLE.
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   rx_i       - raw serial line (asynchronous)
//   tick_i     - OVERSAMPLE x baud tick
//   cnt_clr    - clears the tick counter (has priority over tick_i)
//   rx_sync    - synchronized line level
//   mid_bit    - tick on which the counter reads OVERSAMPLE/2-1
//   bit_end    - tick on which the counter reads OVERSAMPLE-1
module uart_rx_sampler #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_i,
    input  logic tick_i,
    input  logic cnt_clr,
    output logic rx_sync,
    output logic mid_bit,
    output logic bit_end
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] MID_CNT = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] END_CNT = CW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          tick_cnt;

    // Sync flops reset to the idle (high) line level so reset release is
    // never mistaken for a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '1;
            tick_cnt <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            if (cnt_clr)
                tick_cnt <= '0;
            else if (tick_i)
                tick_cnt <= tick_cnt + CW'(1);
        end
    end

    assign rx_sync = sync_q[SYNC_STAGES-1];
    assign mid_bit = tick_i && (tick_cnt == MID_CNT);
    assign bit_end = tick_i && (tick_cnt == END_CNT);

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: start-bit detection, mid-bit sampling of data, parity
// and stop bits, and delivery of the byte to the host via data_valid_o/rd_i.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   rx_i, tick_i      - serial line and OVERSAMPLE x baud tick
//   rx_en_i           - receiver enable; low aborts any frame in progress
//   data_bit_num_i, parity_en_i, parity_type_i, stop_bit_num_i - frame format,
//                       captured while idle
//   rd_i              - host read strobe, clears data_valid_o/overrun_err_o
//   data_o, data_valid_o, rx_done_o - received byte, unread flag, frame pulse
//   parity_err_o, frame_err_o, overrun_err_o - error status
//   rts_no            - active-low ready-to-send (low when the buffer is free)
//   state_dbg         - current FSM state (rx_state_e encoding)
// Host handshake: data_valid_o rises the clk after the final stop sample and
// stays high until a rd_i strobe; a frame completing while it is still high
// overwrites data_o and sets overrun_err_o, unless rd_i lands on that same clk.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    input  logic       tick_i,
    input  logic       rx_en_i,
    input  logic [1:0] data_bit_num_i,
    input  logic       parity_en_i,
    input  logic       parity_type_i,
    input  logic       stop_bit_num_i,
    input  logic       rd_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       rx_done_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overrun_err_o,
    output logic       rts_no,
    output logic [2:0] state_dbg
);

    rx_state_e  state, state_n;
    logic       rx_s, mid_bit, bit_end, cnt_clr;
    logic [1:0] cfg_dbn;
    logic       cfg_par_en, cfg_par_type, cfg_stop2;
    logic [3:0] bit_idx;
    logic       stop_idx;
    logic [7:0] shreg;
    logic       par_err_acc, frame_err_acc, exp_par;
    logic       sample_data, sample_par, sample_stop, frame_done;
    logic       data_valid;

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk    (clk),
        .reset  (reset),
        .rx_i   (rx_i),
        .tick_i (tick_i),
        .cnt_clr(cnt_clr),
        .rx_sync(rx_s),
        .mid_bit(mid_bit),
        .bit_end(bit_end)
    );

    // shreg is zero-filled while idle, so unused MSBs never affect parity.
    uart_parity u_parity (
        .data       (shreg),
        .parity_type(cfg_par_type),
        .parity_bit (exp_par)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // The counter is held clear while idle and re-cleared at mid start bit,
    // so every later bit_end lands in the middle of a bit.
    always_comb begin
        state_n     = state;
        cnt_clr     = 1'b0;
        sample_data = 1'b0;
        sample_par  = 1'b0;
        sample_stop = 1'b0;
        frame_done  = 1'b0;
        if (!rx_en_i) begin
            state_n = IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt_clr = 1'b1;
                    if (tick_i && !rx_s)
                        state_n = START;
                end
                START: begin
                    if (mid_bit) begin
                        cnt_clr = 1'b1;
                        state_n = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        sample_data = 1'b1;
                        if (bit_idx == data_bit_count(cfg_dbn) - 4'd1)
                            state_n = cfg_par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        sample_par = 1'b1;
                        state_n    = STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        sample_stop = 1'b1;
                        if (stop_idx == cfg_stop2) begin
                            frame_done = 1'b1;
                            state_n    = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_dbn       <= 2'b00;
            cfg_par_en    <= 1'b0;
            cfg_par_type  <= 1'b0;
            cfg_stop2     <= 1'b0;
            bit_idx       <= 4'd0;
            stop_idx      <= 1'b0;
            shreg         <= 8'h00;
            par_err_acc   <= 1'b0;
            frame_err_acc <= 1'b0;
            data_o        <= 8'h00;
            data_valid    <= 1'b0;
            rx_done_o     <= 1'b0;
            parity_err_o  <= 1'b0;
            frame_err_o   <= 1'b0;
            overrun_err_o <= 1'b0;
        end else begin
            // Format is captured only while idle so a frame keeps one format.
            if (state == IDLE) begin
                cfg_dbn       <= data_bit_num_i;
                cfg_par_en    <= parity_en_i;
                cfg_par_type  <= parity_type_i;
                cfg_stop2     <= stop_bit_num_i;
                bit_idx       <= 4'd0;
                stop_idx      <= 1'b0;
                shreg         <= 8'h00;
                par_err_acc   <= 1'b0;
                frame_err_acc <= 1'b0;
            end
            if (sample_data) begin
                shreg[bit_idx[2:0]] <= rx_s;
                bit_idx             <= bit_idx + 4'd1;
            end
            if (sample_par)
                par_err_acc <= (rx_s != exp_par);
            if (sample_stop) begin
                frame_err_acc <= frame_err_acc | ~rx_s;
                stop_idx      <= 1'b1;
            end

            rx_done_o <= frame_done;
            if (frame_done) begin
                data_o       <= shreg;
                parity_err_o <= par_err_acc;
                // Include the final stop sample taken on this same clk.
                frame_err_o  <= frame_err_acc | ~rx_s;
            end

            if (frame_done)
                data_valid <= 1'b1;
            else if (rd_i)
                data_valid <= 1'b0;

            // A read on the completion clk consumes the old byte: no overrun.
            if (rd_i)
                overrun_err_o <= 1'b0;
            else if (frame_done && data_valid)
                overrun_err_o <= 1'b1;
        end
    end

    assign data_valid_o = data_valid;
    assign rts_no       = data_valid;
    assign state_dbg    = state;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: tick every TICK_DIV clks, OVERSAMPLE=16.
module tb_uart_receiver;

    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       tick = 1'b0;
    logic       rx_en = 1'b1;
    logic [1:0] dbn = 2'b11;
    logic       par_en = 1'b0;
    logic       par_type = 1'b0;
    logic       stop2 = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] data_o;
    logic       data_valid_o, rx_done_o, parity_err_o, frame_err_o, overrun_err_o, rts_no;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int tdiv = 0;

    // {frame_err, parity_err, data}
    logic [9:0] exp_q[$];

    uart_receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_i          (rx),
        .tick_i        (tick),
        .rx_en_i       (rx_en),
        .data_bit_num_i(dbn),
        .parity_en_i   (par_en),
        .parity_type_i (par_type),
        .stop_bit_num_i(stop2),
        .rd_i          (rd),
        .data_o        (data_o),
        .data_valid_o  (data_valid_o),
        .rx_done_o     (rx_done_o),
        .parity_err_o  (parity_err_o),
        .frame_err_o   (frame_err_o),
        .overrun_err_o (overrun_err_o),
        .rts_no        (rts_no),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / tick ----------------
    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick = (tdiv == TICK_DIV - 1);
        tdiv = (tdiv + 1) % TICK_DIV;
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && rx_done_o) begin
            logic [9:0] exp;
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got data=%h fe=%b pe=%b, expected no frame",
                         data_o, frame_err_o, parity_err_o);
            end else begin
                exp = exp_q.pop_front();
                if ({frame_err_o, parity_err_o, data_o} !== exp) begin
                    errors++;
                    $display("FAIL frame_result got fe=%b pe=%b data=%h, expected fe=%b pe=%b data=%h",
                             frame_err_o, parity_err_o, data_o, exp[9], exp[8], exp[7:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_cfg(input logic [1:0] n, input logic pen, input logic ptype, input logic s2);
        dbn = n; par_en = pen; par_type = ptype; stop2 = s2;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen,
                              input bit pbit, input int nstop, input bit stop_bad);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (pen) begin
            rx = pbit;
            repeat (BIT_CLKS) @(negedge clk);
        end
        for (int s = 0; s < nstop; s++) begin
            if (stop_bad && s == nstop - 1) begin
                // Low across the mid-bit sample, then back to idle.
                rx = 1'b0;
                repeat (BIT_CLKS * 5 / 8) @(negedge clk);
                rx = 1'b1;
                repeat (BIT_CLKS * 3 / 8) @(negedge clk);
            end else begin
                rx = 1'b1;
                repeat (BIT_CLKS) @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4 * BIT_CLKS && exp_q.size() != 0; i++) @(negedge clk);
    endtask

    task automatic host_read();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({data_o, data_valid_o, rx_done_o, parity_err_o, frame_err_o, overrun_err_o} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h v=%b d=%b pe=%b fe=%b ov=%b, expected all 0",
                     data_o, data_valid_o, rx_done_o, parity_err_o, frame_err_o, overrun_err_o);
        end
        checks++;
        if (rts_no !== 1'b0) begin
            errors++; $display("FAIL reset_rts got %b expected 0", rts_no);
        end
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++; $display("FAIL reset_state got %0d expected 0", state_dbg);
        end
    endtask

    task automatic test_8n1();
        int d0;
        d0 = done_cnt;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({2'b00, 8'hA5});
        send_frame(8'hA5, 8, 0, 0, 1, 0);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL 8n1_timeout got pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL 8n1_done_count got %0d expected 1", done_cnt - d0);
        end
        checks++;
        if ({data_valid_o, rts_no, overrun_err_o} !== 3'b110) begin
            errors++; $display("FAIL 8n1_flags got v=%b rts=%b ov=%b expected 1 1 0",
                               data_valid_o, rts_no, overrun_err_o);
        end
        host_read();
        checks++;
        if ({data_valid_o, rts_no} !== 2'b00) begin
            errors++; $display("FAIL 8n1_read got v=%b rts=%b expected 0 0", data_valid_o, rts_no);
        end
    endtask

    task automatic test_parity();
        logic [7:0] d;
        logic good;
        d = 8'h35;
        good = ^d; // even parity
        set_cfg(2'b10, 1'b1, 1'b0, 1'b1);
        exp_q.push_back({1'b0, 1'b1, d});
        send_frame(d, 7, 1, ~good, 2, 0);
        wait_drain();
        checks++;
        if (parity_err_o !== 1'b1 || exp_q.size() != 0) begin
            errors++; $display("FAIL parity_bad got pe=%b pending=%0d expected 1 0", parity_err_o, exp_q.size());
            exp_q.delete();
        end
        host_read();
        exp_q.push_back({1'b0, 1'b0, d});
        send_frame(d, 7, 1, good, 2, 0);
        wait_drain();
        checks++;
        if (parity_err_o !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL parity_good got pe=%b pending=%0d expected 0 0", parity_err_o, exp_q.size());
            exp_q.delete();
        end
        // Odd parity with random 6-bit data
        d = 8'($urandom_range(0, 63));
        set_cfg(2'b01, 1'b1, 1'b1, 1'b0);
        exp_q.push_back({1'b0, 1'b0, d});
        send_frame(d, 6, 1, ~(^d), 1, 0);
        wait_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL parity_odd_timeout got pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        host_read();
    endtask

    task automatic test_glitch();
        int d0;
        logic v0;
        d0 = done_cnt;
        v0 = data_valid_o;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checks++;
        if (done_cnt != d0 || state_dbg !== 3'd0 || data_valid_o !== v0) begin
            errors++; $display("FAIL glitch got done=%0d state=%0d v=%b expected 0 0 %b",
                               done_cnt - d0, state_dbg, data_valid_o, v0);
        end
    endtask

    task automatic test_frame_err();
        set_cfg(2'b00, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({1'b1, 1'b0, 8'h1F});
        send_frame(8'h1F, 5, 0, 0, 1, 1);
        wait_drain();
        checks++;
        if (frame_err_o !== 1'b1 || data_valid_o !== 1'b1) begin
            errors++; $display("FAIL frame_err_set got fe=%b v=%b expected 1 1", frame_err_o, data_valid_o);
        end
        host_read();
        repeat (BIT_CLKS) @(negedge clk);
        exp_q.push_back({1'b0, 1'b0, 8'h0A});
        send_frame(8'h0A, 5, 0, 0, 1, 0);
        wait_drain();
        checks++;
        if (frame_err_o !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL frame_err_clear got fe=%b pending=%0d expected 0 0", frame_err_o, exp_q.size());
            exp_q.delete();
        end
        host_read();
    endtask

    task automatic test_back_to_back();
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({2'b00, 8'h11});
        send_frame(8'h11, 8, 0, 0, 1, 0);
        exp_q.push_back({2'b00, 8'h22});
        send_frame(8'h22, 8, 0, 0, 1, 0);
        wait_drain();
        checks++;
        if (overrun_err_o !== 1'b1 || data_o !== 8'h22 || data_valid_o !== 1'b1) begin
            errors++; $display("FAIL overrun_set got ov=%b data=%h v=%b expected 1 22 1",
                               overrun_err_o, data_o, data_valid_o);
        end
        host_read();
        checks++;
        if ({data_valid_o, overrun_err_o, rts_no} !== 3'b000) begin
            errors++; $display("FAIL overrun_read got v=%b ov=%b rts=%b expected 0 0 0",
                               data_valid_o, overrun_err_o, rts_no);
        end
    endtask

    task automatic test_abort();
        int d0;
        logic [7:0] d;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({2'b00, 8'h77});
        send_frame(8'h77, 8, 0, 0, 1, 0);
        wait_drain();
        // Partial 0xC3 frame, then reset mid-DATA
        d = 8'hC3;
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({data_o, data_valid_o, rts_no, overrun_err_o, frame_err_o, parity_err_o} !== 13'd0
            || state_dbg !== 3'd0) begin
            errors++; $display("FAIL abort_reset got data=%h v=%b rts=%b state=%0d expected 00 0 0 0",
                               data_o, data_valid_o, rts_no, state_dbg);
        end
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        exp_q.push_back({2'b00, 8'h5A});
        send_frame(8'h5A, 8, 0, 0, 1, 0);
        wait_drain();
        checks++;
        if (exp_q.size() != 0 || data_valid_o !== 1'b1) begin
            errors++; $display("FAIL abort_recover got pending=%0d v=%b expected 0 1", exp_q.size(), data_valid_o);
            exp_q.delete();
        end
        host_read();
        // Drop rx_en mid-frame
        d0 = done_cnt;
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx_en = 1'b0;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++; $display("FAIL rx_en_idle got state=%0d expected 0", state_dbg);
        end
        rx_en = 1'b1;
        repeat (12 * BIT_CLKS) @(negedge clk);
        checks++;
        if (done_cnt != d0 || data_valid_o !== 1'b0 || frame_err_o !== 1'b0) begin
            errors++; $display("FAIL rx_en_abort got done=%0d v=%b fe=%b expected 0 0 0",
                               done_cnt - d0, data_valid_o, frame_err_o);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receive path: the counterpart of the existing transmitter on the same UART.
- Oversamples the rx line on the shared baud-generator tick and detects and validates the start bit.
- Samples data, parity and stop bits at mid-bit and presents the assembled byte to the APB register side through a valid/read handshake.
- Reports parity, framing and overrun errors, and drives RTS flow control.

Parameters:
OVERSAMPLE, 16, ticks per bit period (power of two, ≥8)
SYNC_STAGES, 2, flip-flops in the rx input synchronizer

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_i  input  1  serial line, idle high, asynchronous to clk
tick_i  input  1  one-clk pulse at OVERSAMPLE × baud rate
rx_en_i  input  1  receiver enable
data_bit_num_i  input  2  00=5, 01=6, 10=7, 11=8 data bits
parity_en_i  input  1  parity bit present
parity_type_i  input  1  0=even, 1=odd
stop_bit_num_i  input  1  0=one stop bit, 1=two stop bits
rd_i  input  1  host read strobe, one clk; clears data_valid_o
data_o  output  8  received data, LSB-first assembled, unused MSBs zero
data_valid_o  output  1  level: unread byte in data_o
rx_done_o  output  1  one-clk pulse per completed frame
parity_err_o  output  1  parity status of the byte in data_o
frame_err_o  output  1  a stop bit sampled low, for the byte in data_o
overrun_err_o  output  1  sticky; set when a frame completes while data_valid_o=1; cleared by rd_i
rts_no  output  1  active-low ready-to-send; equals data_valid_o

Behaviour:
- Reset: all outputs 0, except rts_no. rts_no=0 because data_valid_o=0. FSM to IDLE; counters and synchronizer cleared (sync flops reset to 1).
- rx_i passes through SYNC_STAGES flops before any use. All FSM and counter activity advances only on tick_i, except the rd_i and host-flag logic.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Synchronized rx=0 on a tick with rx_en_i=1 → START.
  - Tick counter is cleared.
  - data_bit_num_i, parity_en_i, parity_type_i and stop_bit_num_i are latched here. Configuration changes mid-frame have no effect on the current frame.
- START: at tick count OVERSAMPLE/2-1 (mid-bit), rx=0 → DATA with counter cleared; rx=1 → IDLE as a glitch (no flags, no pulse).
- DATA:
  - Every OVERSAMPLE ticks, sample rx into the shift register, LSB first.
  - After N bits → PARITY if parity_en, else STOP.
- PARITY: sample once. parity_err = sample ≠ expected. Expected is computed by the existing parity block over the zero-filled assembled byte (even: XOR of data; odd: its inverse).
- STOP: sample 1 or 2 stop bits. Any low sample sets frame_err for this frame.
- Frame completion (clk after the final stop sample):
  - rx_done_o pulses for one clk.
  - data_o, parity_err_o and frame_err_o update.
  - data_valid_o is set.
  - If data_valid_o was already 1, overrun_err_o is set and data_o is overwritten by the new byte.
  - FSM → IDLE in the same cycle, so a start bit immediately after the last stop bit mid-sample is detected.
- Frames with errors are still delivered (data_valid_o=1).
- rd_i clears data_valid_o and overrun_err_o next clk. If rd_i coincides with frame completion: the new byte sets data_valid_o=1, and no overrun is flagged.
- rx_en_i=0 in any state → IDLE on the next clk. The partial frame is discarded and no flags change.
- Reset asserted mid-frame → immediate return to reset values.
- Latency: rx_done_o occurs at most 3 clk after the tick of the last stop mid-sample.

Decomposition:
- Package uart_pkg:
  - rx_state_e enum (IDLE, START, DATA, PARITY, STOP)
  - data_bit_num encodings and a width-to-count function
  - PARITY_EVEN/ODD constants
- Sub-module uart_rx_sampler: rx synchronizer plus mod-OVERSAMPLE tick counter, producing mid_bit and bit_end strobes.
- The parity generator is instantiated unchanged.

Test Plan:
1. 8N1 (data_bit_num=11, parity_en=0, stop=0), OVERSAMPLE=16, send 0xA5 → one rx_done_o pulse; data_o=0xA5; data_valid_o=1; rts_no=1; all error flags 0.
2. 7E2 (10, parity_en=1, type=0), send 0x35 with parity bit 1 (correct is 0) → data_o=0x35, parity_err_o=1, frame_err_o=0. Resend with parity 0 → parity_err_o=0.
3. rx low for 4 ticks then high, idle afterwards → no rx_done_o, FSM back in IDLE, data_valid_o unchanged.
4. 5N1 send 0x1F with stop bit driven low → data_o=0x1F, frame_err_o=1; the next clean frame clears it.
5. Two 8N1 frames 0x11 then 0x22 without rd_i → overrun_err_o=1, data_o=0x22. Then rd_i → data_valid_o=0, overrun_err_o=0, rts_no=0.
6. Abort mid-frame:
   - Assert reset mid-DATA of 0xC3 → outputs return to reset values; a following 0x5A is received correctly.
   - Drop rx_en_i mid-frame → no rx_done_o.
